// File: rtl/pwm_complement_multich.sv
// Centre-aligned complementary PWM: CHANNELS half-bridge legs share one up/down carrier,
// double-buffered settings load at the valley, per-leg ON-delay dead time.
// Optional fault latch (fault, fault_clr, fault_latched) when PWM_FAULT_INPUT_EN is defined.
module pwm_complement_multich #(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 8,
  parameter int DT_W     = 8
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      enable,
  input  logic [CNT_W-1:0]          period,
  input  logic [CHANNELS*CNT_W-1:0] duty,
  input  logic [DT_W-1:0]           dead_time,
  input  logic                      load,
`ifdef PWM_FAULT_INPUT_EN
  input  logic                      fault,
  input  logic                      fault_clr,
  output logic                      fault_latched,
`endif
  output logic [CHANNELS-1:0]       pwm_h,
  output logic [CHANNELS-1:0]       pwm_l,
  output logic                      valley,
  output logic                      load_pending
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam logic [DT_W-1:0] DT_MAX = '1;

  logic [CNT_W-1:0]                 count, count_next;
  dir_t                             dir, dir_next;
  logic [CNT_W-1:0]                 per_s;
  logic [CHANNELS-1:0][CNT_W-1:0]   duty_s;
  logic [DT_W-1:0]                  dt_s;
  logic [CHANNELS-1:0][DT_W-1:0]    dcnt_h, dcnt_l;
  logic [CHANNELS-1:0]              h_raw;
  logic                             reversal, load_point, apply, out_block;

  assign reversal = (count == '0) && (dir == DIR_DOWN);
  // An idle carrier (per_s = 0) never reverses, so it accepts settings straight away;
  // otherwise the first load after reset could never take effect.
  assign load_point = enable && (count == '0) && ((dir == DIR_DOWN) || (per_s == '0));
  assign apply      = load_pending && load_point;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave it unassigned (no latch).
    count_next = count;
    dir_next   = dir;
    if (!enable || per_s == '0) begin
      count_next = '0;
      dir_next   = DIR_UP;
    end else if (dir == DIR_UP) begin
      if (count < per_s) begin
        count_next = count + 1'b1;
      end else begin
        dir_next   = DIR_DOWN;
        count_next = count - 1'b1;
      end
    end else begin
      if (count != '0) begin
        count_next = count - 1'b1;
      end else begin
        dir_next   = DIR_UP;
        count_next = count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
      dir   <= DIR_UP;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the order.
      count <= count_next;
      dir   <= dir_next;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      // NOTE: the shadows are a few plain registers, not a memory array, so they take the reset.
      per_s        <= '0;
      duty_s       <= '0;
      dt_s         <= '0;
      load_pending <= 1'b0;
      valley       <= 1'b0;
    end else begin
      valley <= enable && reversal;
      if (load) begin
        load_pending <= 1'b1;
      end else if (apply) begin
        load_pending <= 1'b0;
      end
      if (apply) begin
        per_s  <= period;
        duty_s <= duty;
        dt_s   <= dead_time;
      end
    end
  end

  always_comb begin
    h_raw = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      h_raw[i] = (count < duty_s[i]);
    end
  end

`ifdef PWM_FAULT_INPUT_EN
  logic fault_meta, fault_s;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fault_meta    <= 1'b0;
      fault_s       <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      fault_meta <= fault;
      fault_s    <= fault_meta;
      if (fault_s) begin
        fault_latched <= 1'b1;
      end else if (fault_clr) begin
        fault_latched <= 1'b0;
      end
    end
  end

  assign out_block = fault_s | fault_latched;
`else
  assign out_block = 1'b0;
`endif

  // Run length of a raw level, saturating; a leg drives once the run has reached dt_s.
  function automatic logic [DT_W-1:0] run_step(input logic raw, input logic [DT_W-1:0] run);
    if (!raw) return '0;
    return (run == DT_MAX) ? run : run + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pwm_h  <= '0;
      pwm_l  <= '0;
      dcnt_h <= '0;
      dcnt_l <= '0;
    end else if (!enable || out_block) begin
      pwm_h  <= '0;
      pwm_l  <= '0;
      dcnt_h <= '0;
      dcnt_l <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_h[i]  <= h_raw[i] && (dcnt_h[i] >= dt_s);
        pwm_l[i]  <= !h_raw[i] && (dcnt_l[i] >= dt_s);
        dcnt_h[i] <= run_step(h_raw[i], dcnt_h[i]);
        dcnt_l[i] <= run_step(!h_raw[i], dcnt_l[i]);
      end
    end
  end

endmodule
